// File: rtl/seg7_display_ctrl_if.sv
// seg7_display_ctrl_if
//   Write-port bundle between the CPU memory-mapped I/O side and the
//   seven-segment display controller.
//   Signals:
//     we        write strobe, one cycle
//     wdata     unsigned value to display (DATA_W bits)
//     mode      sampled with we: 0 = hex, 1 = decimal
//     blink_en  1 makes the display blink
//     busy      decimal conversion running; writes are dropped
//     ovf       last written value did not fit in NUM_DIGITS digits
//     seg       7 segments per digit, {g,f,e,d,c,b,a}, digit 0 rightmost
//   Modports: master = CPU side, slave = display controller.
interface seg7_display_ctrl_if #(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 24
);
  logic                    we;
  logic [DATA_W-1:0]       wdata;
  logic                    mode;
  logic                    blink_en;
  logic                    busy;
  logic                    ovf;
  logic [7*NUM_DIGITS-1:0] seg;

  modport master (output we, wdata, mode, blink_en, input busy, ovf, seg);
  modport slave  (input we, wdata, mode, blink_en, output busy, ovf, seg);
endinterface

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl
//   Multi-digit seven-segment display controller. Latches a value written by
//   the core and shows it in hex or decimal on NUM_DIGITS digits. Decimal
//   values go through an iterative double-dabble converter (one bit per
//   cycle). Provides overflow indication and optional blinking.
//   Ports:
//     clk   system clock, everything on the rising edge
//     rst   synchronous active-high reset
//     bus   seg7_display_ctrl_if.slave (we, wdata, mode, blink_en in;
//           busy, ovf, seg out)
//   Build option: define SEG7_LZB_EN for leading-zero blanking (digit 0 is
//   never blanked, the '-' overflow pattern is never blanked).
module seg7_display_ctrl #(
  parameter int NUM_DIGITS     = 6,
  parameter int DATA_W         = 24,
  parameter int BLINK_DIV      = 25_000_000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  seg7_display_ctrl_if.slave bus
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int SW    = 7 * NUM_DIGITS;
  localparam int EXTW  = (DATA_W > DW) ? DATA_W : DW;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BLK_W = $clog2(BLINK_DIV);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  localparam logic [6:0]    DASH = 7'b1000000;
  localparam logic [SW-1:0] POL  = (SEG_ACTIVE_LOW != 0) ? {SW{1'b1}} : '0;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DW-1:0]     bcd;
  logic [DW-1:0]     bcd_adj;
  logic              conv_ovf;
  logic [DW-1:0]     digits;
  logic              dash;
  logic              valid;
  logic              ovf_q;
  logic              busy_q;
  logic [BLK_W-1:0]  blk_cnt;
  logic              blk_wrap;
  logic              phase;
  logic [SW-1:0]     seg_q;

  logic [EXTW-1:0]   wext;
  logic              hex_ovf;
  logic [DW-1:0]     nxt_digits;
  logic              nxt_dash;
  logic              nxt_valid;
  logic              nxt_phase;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  // Builds the full segment word (active-high) and then applies the board
  // polarity as the very last step, so "unlit" is uniform everywhere.
  function automatic logic [SW-1:0] render(input logic [DW-1:0] d, input logic dsh,
                                           input logic vld, input logic blank);
    logic [6:0]    g;
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dsh) begin
        g = DASH;
      end else begin
        g = hex7(d[4*i +: 4]);
`ifdef SEG7_LZB_EN
        if (i != 0 && (d >> (4 * i)) == '0) g = '0;
`endif
      end
      if (!vld || blank) g = '0;
      r[7*i +: 7] = g;
    end
    return r ^ POL;
  endfunction

  assign wext    = EXTW'(bus.wdata);
  assign hex_ovf = |(wext >> DW);

  // One double-dabble correction step: every BCD nibble of 5 or more gets +3
  // so that the following left shift carries correctly into the next digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Next display contents. SEG is registered from these next values so a hex
  // write still shows up one cycle later without a comb path from we to seg.
  always_comb begin
    nxt_digits = digits;
    nxt_dash   = dash;
    nxt_valid  = valid;
    if (state == IDLE && bus.we && !bus.mode) begin
      nxt_digits = wext[DW-1:0];
      nxt_dash   = 1'b0;
      nxt_valid  = 1'b1;
    end else if (state == LOAD) begin
      nxt_digits = bcd;
      nxt_dash   = conv_ovf;
      nxt_valid  = 1'b1;
    end
  end

  assign blk_wrap  = (blk_cnt == BLK_W'(BLINK_DIV - 1));
  assign nxt_phase = phase ^ blk_wrap;

  // Display registers and the free-running blink divider. The divider keeps
  // counting whether or not blinking is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits  <= '0;
      dash    <= 1'b0;
      valid   <= 1'b0;
      blk_cnt <= '0;
      phase   <= 1'b0;
      seg_q   <= POL;
    end else begin
      digits  <= nxt_digits;
      dash    <= nxt_dash;
      valid   <= nxt_valid;
      blk_cnt <= blk_wrap ? '0 : blk_cnt + BLK_W'(1);
      phase   <= nxt_phase;
      seg_q   <= render(nxt_digits, nxt_dash, nxt_valid, bus.blink_en && nxt_phase);
    end
  end

  // Write/conversion FSM. A 1 shifted out of the top BCD nibble means the
  // value needs more than NUM_DIGITS decimal digits. Writes outside IDLE are
  // dropped without any effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      bcd      <= '0;
      conv_ovf <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.we) begin
            if (!bus.mode) begin
              ovf_q <= hex_ovf;
            end else begin
              shreg    <= bus.wdata;
              bcd      <= '0;
              conv_ovf <= 1'b0;
              cnt      <= '0;
              busy_q   <= 1'b1;
              state    <= CONV;
            end
          end
        end
        CONV: begin
          {bcd, shreg} <= {bcd_adj[DW-2:0], shreg, 1'b0};
          conv_ovf     <= conv_ovf | bcd_adj[DW-1];
          cnt          <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) state <= LOAD;
        end
        LOAD: begin
          ovf_q  <= conv_ovf;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_q;
  assign bus.seg  = seg_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl
//   Self-checking bench for seg7_display_ctrl with NUM_DIGITS=6, DATA_W=24,
//   BLINK_DIV=4, active-low segments. Expected displays come from a small
//   reference model (hex nibbles or repeated divide-by-10) and sit in a
//   scoreboard queue until the DUT presents its result.
module tb_seg7_display_ctrl;
  localparam int ND = 6;
  localparam int DW = 24;
  localparam int BD = 4;
  localparam int SW = 7 * ND;
  localparam logic [SW-1:0] BLANK = {SW{1'b1}};

  typedef struct {
    logic [SW-1:0] seg;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int testsRun = 0;
  int testsFailed = 0;
  exp_t sbq[$];
  logic [SW-1:0] lastShown = BLANK;

  seg7_display_ctrl_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus ();

  seg7_display_ctrl #(
    .NUM_DIGITS(ND), .DATA_W(DW), .BLINK_DIV(BD), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  // Reference display for a write: hex nibbles, or decimal digits by repeated
  // division; more than six decimal digits gives the all-dash pattern.
  function automatic exp_t model(input logic m, input logic [DW-1:0] v);
    exp_t e;
    logic [3:0] nib [ND];
    logic [SW-1:0] raw;
    bit dashAll;
    int x;
`ifdef SEG7_LZB_EN
    bit leading;
`endif
    raw = '0;
    dashAll = 1'b0;
    x = int'(v);
    if (m && x > 999999) dashAll = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (!m) begin
        nib[i] = v[4*i +: 4];
      end else begin
        nib[i] = 4'(x % 10);
        x = x / 10;
      end
    end
`ifdef SEG7_LZB_EN
    leading = 1'b1;
`endif
    for (int i = ND - 1; i >= 0; i--) begin
      if (dashAll) begin
        raw[7*i +: 7] = 7'b1000000;
      end else begin
        raw[7*i +: 7] = glyph(nib[i]);
`ifdef SEG7_LZB_EN
        if (leading && i > 0 && nib[i] == 4'd0) raw[7*i +: 7] = '0;
        else leading = 1'b0;
`endif
      end
    end
    e.seg = ~raw;
    e.ovf = dashAll;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drives one write, queues its expected result, then waits for the DUT
  // (bounded) and compares. injectAt > 0 fires a stray write mid-conversion.
  task automatic applyStimulus(input logic m, input logic [DW-1:0] v, input int injectAt);
    exp_t e;
    int n;
    @(negedge clk);
    bus.we = 1'b1;
    bus.mode = m;
    bus.wdata = v;
    sbq.push_back(model(m, v));
    @(negedge clk);
    bus.we = 1'b0;
    if (!m) begin
      checkOutput("hex_busy", 64'(bus.busy), 64'd0);
    end else begin
      checkOutput("dec_busy_start", 64'(bus.busy), 64'd1);
      n = 0;
      while (bus.busy && n < 200) begin
        n++;
        if (n == 10) checkOutput("dec_hold", 64'(bus.seg), 64'(lastShown));
        if (n == injectAt) begin
          bus.we = 1'b1;
          bus.mode = 1'b0;
          bus.wdata = 24'd1;
        end else begin
          bus.we = 1'b0;
        end
        @(negedge clk);
      end
      bus.we = 1'b0;
      checkOutput("dec_busy_len", 64'(n), 64'(DW + 1));
    end
    e = sbq.pop_front();
    checkOutput("seg", 64'(bus.seg), 64'(e.seg));
    checkOutput("ovf", 64'(bus.ovf), 64'(e.ovf));
    lastShown = e.seg;
  endtask

  initial begin
    logic [SW-1:0] shown;
    bit prevBlank, curBlank, seenChange;
    int runLen, changes;

    bus.we = 1'b0;
    bus.mode = 1'b0;
    bus.wdata = '0;
    bus.blink_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_ovf", 64'(bus.ovf), 64'd0);
    checkOutput("rst_seg", 64'(bus.seg), 64'(BLANK));

    applyStimulus(1'b0, 24'h12AB3F, 0);
    checkOutput("hex_digit0", 64'(bus.seg[6:0]), 64'(7'b0001110));

    applyStimulus(1'b1, 24'd987654, 5);
    applyStimulus(1'b1, 24'd999999, 0);
    applyStimulus(1'b1, 24'd42, 0);
    applyStimulus(1'b1, 24'd1000000, 0);
    checkOutput("dash_digit5", 64'(bus.seg[41:35]), 64'(7'b0111111));
    applyStimulus(1'b1, 24'd0, 0);

    // Blink: every sample is either the shown value or blank, and once
    // toggling is under way each run lasts exactly BD cycles.
    applyStimulus(1'b0, 24'h12AB3F, 0);
    shown = lastShown;
    bus.blink_en = 1'b1;
    @(negedge clk);
    prevBlank = (bus.seg == BLANK);
    seenChange = 1'b0;
    runLen = 1;
    changes = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      curBlank = (bus.seg == BLANK);
      checkOutput("blink_glyph", 64'(curBlank || bus.seg == shown), 64'd1);
      if (curBlank != prevBlank) begin
        if (seenChange) checkOutput("blink_run", 64'(runLen), 64'(BD));
        seenChange = 1'b1;
        changes++;
        runLen = 1;
      end else begin
        runLen++;
      end
      prevBlank = curBlank;
    end
    checkOutput("blink_toggles", 64'(changes >= 4), 64'd1);
    bus.blink_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      checkOutput("steady", 64'(bus.seg), 64'(shown));
      @(negedge clk);
    end

    // Reset in the middle of a decimal conversion throws the result away.
    bus.we = 1'b1;
    bus.mode = 1'b1;
    bus.wdata = 24'd123456;
    @(negedge clk);
    bus.we = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midrst_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
    checkOutput("midrst_seg", 64'(bus.seg), 64'(BLANK));
    checkOutput("midrst_ovf", 64'(bus.ovf), 64'd0);
    lastShown = BLANK;
    applyStimulus(1'b0, 24'h000123, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
